// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop bit and device acknowledge, with an overall timeout.
//
// Ports:
//   Clk         system clock (only clock in the block)
//   reset       synchronous, active-high
//   tx_data     byte to send to the device
//   tx_start    one-cycle send request, taken only when idle
//   psClk       raw PS/2 clock line level (asynchronous)
//   psData      raw PS/2 data line level (asynchronous)
//   psClk_low   1 = pull PS/2 clock low, 0 = release
//   psData_low  1 = pull PS/2 data low, 0 = release
//   busy        transfer in progress
//   done        one-cycle pulse, byte sent and acknowledged
//   error       one-cycle pulse, timeout or missing acknowledge
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       psClk,
   input  logic       psData,
   output logic       psClk_low,
   output logic       psData_low,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_REQUEST,
      S_BITS,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t state, state_n;

   logic          clk_meta, clk_sync, clk_prev;
   logic          data_meta, data_sync;
   logic          fall;

   logic [IW-1:0] inh_cnt, inh_n;
   logic [TW-1:0] to_cnt, to_n;
   logic [8:0]    shift, shift_n;
   logic [3:0]    bit_cnt, bit_n;
   logic          dlow, dlow_n;
   logic          done_n, error_n;
   logic          clk_low_n, data_low_n;
   logic          active;

   // Two-flop synchronizers; lines idle high, so reset them to 1.
   always_ff @(posedge Clk) begin
      if (reset) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= psClk;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= psData;
         data_sync <= data_meta;
      end
   end

   assign fall = clk_prev & ~clk_sync;

   assign active = (state == S_REQUEST) || (state == S_BITS) ||
                   (state == S_ACK) || (state == S_WAIT_IDLE);

   always_ff @(posedge Clk) begin
      if (reset) begin
         state      <= S_IDLE;
         inh_cnt    <= '0;
         to_cnt     <= '0;
         shift      <= '0;
         bit_cnt    <= '0;
         dlow       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         psClk_low  <= 1'b0;
         psData_low <= 1'b0;
      end else begin
         state      <= state_n;
         inh_cnt    <= inh_n;
         to_cnt     <= to_n;
         shift      <= shift_n;
         bit_cnt    <= bit_n;
         dlow       <= dlow_n;
         done       <= done_n;
         error      <= error_n;
         psClk_low  <= clk_low_n;
         psData_low <= data_low_n;
      end
   end

   always_comb begin
      state_n = state;
      inh_n   = inh_cnt;
      to_n    = to_cnt;
      shift_n = shift;
      bit_n   = bit_cnt;
      dlow_n  = dlow;
      done_n  = 1'b0;
      error_n = 1'b0;

      unique case (state)
         S_IDLE: begin
            dlow_n = 1'b0;
            if (tx_start) begin
               shift_n = {~^tx_data, tx_data};
               bit_n   = '0;
               inh_n   = '0;
               state_n = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
               inh_n   = '0;
               to_n    = '0;
               state_n = S_REQUEST;
            end else begin
               inh_n = inh_cnt + IW'(1);
            end
         end
         S_REQUEST: begin
            if (fall) begin
               dlow_n  = ~shift[0];
               shift_n = {1'b0, shift[8:1]};
               bit_n   = 4'd1;
               state_n = S_BITS;
            end
         end
         S_BITS: begin
            if (fall) begin
               if (bit_cnt == 4'd9) begin
                  // Stop bit: release data and await the device ack.
                  dlow_n  = 1'b0;
                  state_n = S_ACK;
               end else begin
                  dlow_n  = ~shift[0];
                  shift_n = {1'b0, shift[8:1]};
                  bit_n   = bit_cnt + 4'd1;
               end
            end
         end
         S_ACK: begin
            if (fall) begin
               if (data_sync) begin
                  error_n = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  state_n = S_WAIT_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               done_n  = 1'b1;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Timeout has priority over any protocol event in the same cycle.
      if (active) begin
         if (to_cnt == TO_LAST) begin
            done_n  = 1'b0;
            error_n = 1'b1;
            dlow_n  = 1'b0;
            state_n = S_IDLE;
         end else begin
            to_n = to_cnt + TW'(1);
         end
      end
   end

   // Line drives are registered from next-state so the pads never glitch.
   always_comb begin
      clk_low_n  = (state_n == S_INHIBIT);
      data_low_n = 1'b0;
      unique case (state_n)
         S_INHIBIT: data_low_n = (inh_n == INH_LAST);
         S_REQUEST: data_low_n = 1'b1;
         S_BITS:    data_low_n = dlow_n;
         default:   data_low_n = 1'b0;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model plus expected-result scoreboard.
// Covers normal sends, parity cases, NACK, timeout, reset and retrigger.
module tb_ps2_host_tx;

   localparam int INH  = 50;
   localparam int TOC  = 2000;
   localparam int HALF = 20;

   logic       clk;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       psClk_low, psData_low, busy, done, error;
   logic       dev_clk, dev_data;
   logic       ps_clk, ps_data;
   logic [9:0] dev_bits;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         is_err;
      bit         chk_bits;
      logic [7:0] data;
      bit         par;
   } exp_t;

   exp_t q[$];

   // Open-drain wired-AND of host and device drivers.
   assign ps_clk  = dev_clk & ~psClk_low;
   assign ps_data = dev_data & ~psData_low;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TOC)
   ) dut (
      .Clk(clk),
      .reset(reset),
      .tx_data(tx_data),
      .tx_start(tx_start),
      .psClk(ps_clk),
      .psData(ps_data),
      .psClk_low(psClk_low),
      .psData_low(psData_low),
      .busy(busy),
      .done(done),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every done/error pulse consumes one expectation.
   always @(negedge clk) begin
      if (done === 1'b1 || error === 1'b1) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", {30'd0, done, error}, 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_kind", {30'd0, done, error},
                  e.is_err ? 32'd1 : 32'd2);
            if (e.chk_bits)
               check("frame_bits", {22'd0, dev_bits},
                     {22'd0, 1'b1, e.par, e.data});
         end
      end
   end

   // Inhibit monitor: clock held low INH cycles, start bit only in last.
   int  run = 0;
   int  dl_n = 0;
   bit  last_dl = 0;
   bit  was_low = 0;
   always @(negedge clk) begin
      if (psClk_low === 1'b1) begin
         run++;
         if (psData_low === 1'b1) dl_n++;
         last_dl = (psData_low === 1'b1);
         was_low = 1;
      end else if (was_low) begin
         check("inhibit_len", run, INH);
         check("inhibit_start", {30'd0, dl_n == 1, last_dl}, 32'd3);
         run = 0;
         dl_n = 0;
         was_low = 0;
      end
   end

   task automatic pulse(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_request(output bit ok);
      int t;
      t = 0;
      while (psClk_low !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      ok = (psClk_low === 1'b1);
      t = 0;
      while (psClk_low === 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      ok = ok && (psClk_low === 1'b0);
      check("request_seen", {31'd0, ok}, 32'd1);
   endtask

   // Device: clocks nclk bits in, then optionally answers with ACK/NACK.
   task automatic device_run(input bit ack, input int nclk);
      bit ok;
      dev_bits = '0;
      wait_request(ok);
      if (!ok) return;
      repeat (4) @(negedge clk);
      check("start_bit", {31'd0, ps_data}, 32'd0);
      for (int i = 0; i < nclk && i < 10; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         dev_bits[i] = ps_data;
         repeat (HALF) @(negedge clk);
      end
      if (nclk < 10) return;
      dev_data = ack ? 1'b0 : 1'b1;
      dev_clk  = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((q.size() != 0 || busy) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check(name, q.size(), 0);
   endtask

   task automatic send(input logic [7:0] b, input bit par, input bit ack);
      q.push_back('{is_err: !ack, chk_bits: 1'b1, data: b, par: par});
      pulse(b);
      device_run(ack, 10);
      drain("send_drain");
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit ok;
      reset    = 1'b1;
      tx_data  = 8'h00;
      tx_start = 1'b0;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      dev_bits = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {27'd0, psClk_low, psData_low, busy, done, error}, 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 0xED: bits LSB-first 1,0,1,1,0,1,1,1; parity 1.
      send(8'hED, 1'b1, 1'b1);
      send(8'h01, 1'b0, 1'b1);
      send(8'hFF, 1'b1, 1'b1);

      // Device holds data high at the ack clock.
      send(8'hAA, 1'b1, 1'b0);

      // Device never clocks: timeout TOC cycles after request entry.
      q.push_back('{is_err: 1'b1, chk_bits: 1'b0, data: 8'h00, par: 1'b0});
      pulse(8'h5A);
      wait_request(ok);
      n = 0;
      while (error !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TOC);
      check("timeout_release",
            {29'd0, psClk_low, psData_low, busy}, 32'd0);
      drain("timeout_drain");

      // Reset after the 4th bit (D3 of 0x55 is 0, so data is pulled low).
      pulse(8'h55);
      device_run(1'b1, 4);
      check("pre_reset_data_low", {31'd0, psData_low}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("reset_release", {29'd0, psClk_low, psData_low, busy}, 32'd0);
      q.push_back('{is_err: 1'b0, chk_bits: 1'b1, data: 8'hF4, par: 1'b0});
      reset    = 1'b0;
      tx_data  = 8'hF4;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check("accept_after_reset", {31'd0, busy}, 32'd1);
      device_run(1'b1, 10);
      drain("reset_drain");

      // Second start during BITS must be ignored.
      q.push_back('{is_err: 1'b0, chk_bits: 1'b1, data: 8'h3C, par: 1'b1});
      pulse(8'h3C);
      fork
         device_run(1'b1, 10);
         begin
            n = 0;
            while (psClk_low === 1'b1 && n < 3000) begin
               @(negedge clk);
               n++;
            end
            repeat (200) @(negedge clk);
            pulse(8'hC3);
         end
      join
      drain("retrigger_drain");
      repeat (100) @(negedge clk);
      check("no_extra_transfer", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
